crank_cam_gen: RTL and testbench

Parametrised crank/cam trigger-wheel signal generator for the hwag angle-capture path. It produces a VR-style crank tooth signal on an N-minus-M wheel, with the gap stretched over the missing teeth, plus a cam window signal keyed to a two-revolution phase. Tooth speed can ramp at runtime. It drives hwag `cap_in` in benches and on the FPGA self-test build, replacing ad-hoc stimulus loops.

---
 rtl/hwag_gen_pkg.sv | 23 ++
 rtl/crank_cam_presc.sv | 61 ++++++
 rtl/crank_cam_gen.sv | 160 ++++++++++++++++
 tb/tb_crank_cam_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_gen_pkg.sv
// Shared types and width helpers for the crank/cam trigger-wheel generator.
// Default wheel constants describe a 60-2 crank wheel.
package hwag_gen_pkg;

  typedef enum logic [1:0] {
    GEN_STOP  = 2'd0,
    GEN_TOOTH = 2'd1,
    GEN_GAP   = 2'd2
  } gen_state_e;

  localparam int DEF_TEETH_TOTAL   = 60;
  localparam int DEF_TEETH_MISSING = 2;

  function automatic int tooth_w(input int teeth_total);
    return $clog2(teeth_total);
  endfunction

  // Wide enough for (missing+1)*(tooth_ticks+1)-1 on the stretched tooth.
  function automatic int period_w(input int tick_w, input int teeth_missing);
    return tick_w + $clog2(teeth_missing + 2);
  endfunction

endpackage

// File: rtl/crank_cam_presc.sv
// Tick prescaler: one tick every presc_cur+1 clocks, with a per-tooth ramp
// of presc_cur that saturates at ramp_limit.
module crank_cam_presc #(
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ena_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               ramp_en_i,
  input  logic               ramp_dir_i,
  input  logic [PRESC_W-1:0] presc_top_i,
  input  logic [PRESC_W-1:0] ramp_limit_i,
  output logic               tick_o,
  output logic [PRESC_W-1:0] presc_cur_o
);

  logic [PRESC_W-1:0] scnt_q, scnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_eff_s;

  // While stopped the live presc_top is the divider, so a run started
  // straight out of reset still gets its first tick after presc_top+1 clocks.
  always_comb begin
    presc_eff_s = load_i ? presc_top_i : presc_q;
    tick_o      = ena_i && (scnt_q == presc_eff_s);
    scnt_d      = scnt_q;
    presc_d     = presc_eff_s;
    if (!ena_i) begin
      scnt_d  = '0;
      presc_d = presc_top_i;
    end else begin
      if (tick_o) begin
        scnt_d = '0;
      end else begin
        scnt_d = scnt_q + PRESC_W'(1);
      end
      if (step_i && ramp_en_i && ramp_dir_i && (presc_eff_s < ramp_limit_i)) begin
        presc_d = presc_eff_s + PRESC_W'(1);
      end else if (step_i && ramp_en_i && !ramp_dir_i && (presc_eff_s > ramp_limit_i)) begin
        presc_d = presc_eff_s - PRESC_W'(1);
      end else begin
        presc_d = presc_eff_s;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scnt_q  <= '0;
      presc_q <= '0;
    end else begin
      scnt_q  <= scnt_d;
      presc_q <= presc_d;
    end
  end

  assign presc_cur_o = presc_q;

endmodule

// File: rtl/crank_cam_gen.sv
// N-minus-M crank tooth generator with a stretched gap tooth and a cam window
// keyed to the two-revolution phase; all outputs are registered.
module crank_cam_gen
  import hwag_gen_pkg::*;
#(
  parameter int   TEETH_TOTAL   = DEF_TEETH_TOTAL,
  parameter int   TEETH_MISSING = DEF_TEETH_MISSING,
  parameter int   PRESC_W       = 8,
  parameter int   TICK_W        = 8,
  parameter logic CAM_ACTIVE    = 1'b0,
  localparam int  TOOTH_W       = tooth_w(TEETH_TOTAL)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ena_i,
  input  logic [PRESC_W-1:0] presc_top_i,
  input  logic [TICK_W-1:0]  tooth_ticks_i,
  input  logic               ramp_en_i,
  input  logic               ramp_dir_i,
  input  logic [PRESC_W-1:0] ramp_limit_i,
  input  logic [TOOTH_W-1:0] start_tooth_i,
  input  logic [TOOTH_W-1:0] cam_on_tooth_i,
  input  logic [TOOTH_W-1:0] cam_off_tooth_i,
  output logic               vr_o,
  output logic               cam_o,
  output logic [TOOTH_W-1:0] tooth_o,
  output logic               gap_o,
  output logic               phase_o,
  output logic               rev_strobe_o,
  output logic [PRESC_W-1:0] presc_cur_o
);

  localparam int PERIOD_W   = period_w(TICK_W, TEETH_MISSING);
  localparam int REAL_TEETH = TEETH_TOTAL - TEETH_MISSING;
  localparam logic [TOOTH_W-1:0]  LAST_TOOTH = TOOTH_W'(REAL_TEETH - 1);
  localparam logic [PERIOD_W-1:0] GAP_MULT   = PERIOD_W'(TEETH_MISSING + 1);

  gen_state_e state_q, state_d;
  logic [TOOTH_W-1:0]  tooth_q, tooth_d;
  logic [PERIOD_W-1:0] tckc_q, tckc_d;
  logic [TICK_W-1:0]   tt_q, tt_d;
  logic vr_q, vr_d, cam_q, cam_d, gap_q, gap_d, phase_q, phase_d, rev_q, rev_d;

  logic                tick_s, boundary_s, wrap_s;
  logic [TICK_W-1:0]   tt_eff_s;
  logic [PERIOD_W-1:0] period_s;
  logic [TOOTH_W-1:0]  next_tooth_s, start_ld_s;

  crank_cam_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ena_i        (ena_i),
    .load_i       (state_q == GEN_STOP),
    .step_i       (boundary_s),
    .ramp_en_i    (ramp_en_i),
    .ramp_dir_i   (ramp_dir_i),
    .presc_top_i  (presc_top_i),
    .ramp_limit_i (ramp_limit_i),
    .tick_o       (tick_s),
    .presc_cur_o  (presc_cur_o)
  );

  // Tooth period in ticks (minus one); the last tooth spans the missing ones.
  always_comb begin
    tt_eff_s = (state_q == GEN_STOP) ? tooth_ticks_i : tt_q;
    if (tooth_q == LAST_TOOTH) begin
      period_s = GAP_MULT * (PERIOD_W'(tt_eff_s) + PERIOD_W'(1)) - PERIOD_W'(1);
    end else begin
      period_s = PERIOD_W'(tt_eff_s);
    end
    boundary_s   = tick_s && (tckc_q == period_s);
    wrap_s       = (tooth_q == LAST_TOOTH);
    next_tooth_s = wrap_s ? '0 : tooth_q + TOOTH_W'(1);
    start_ld_s   = (start_tooth_i < TOOTH_W'(REAL_TEETH)) ? start_tooth_i : '0;
  end

  always_comb begin
    state_d = state_q;
    tooth_d = tooth_q;
    tckc_d  = tckc_q;
    tt_d    = tt_q;
    vr_d    = vr_q;
    cam_d   = cam_q;
    phase_d = phase_q;
    rev_d   = 1'b0;
    gap_d   = gap_q;
    if (!ena_i) begin
      state_d = GEN_STOP;
      tooth_d = start_ld_s;
      tckc_d  = '0;
      tt_d    = tooth_ticks_i;
      vr_d    = 1'b0;
      cam_d   = ~CAM_ACTIVE;
      phase_d = 1'b0;
      gap_d   = (start_ld_s == LAST_TOOTH);
    end else begin
      tt_d = tt_eff_s;
      if (boundary_s) begin
        tckc_d  = '0;
        vr_d    = 1'b0;
        tooth_d = next_tooth_s;
        tt_d    = tooth_ticks_i;
        phase_d = wrap_s ? ~phase_q : phase_q;
        rev_d   = wrap_s;
        // Off is tested first so it wins when both edges name the same tooth.
        if (next_tooth_s == cam_off_tooth_i) begin
          cam_d = ~CAM_ACTIVE;
        end else if ((next_tooth_s == cam_on_tooth_i) && phase_d) begin
          cam_d = CAM_ACTIVE;
        end else begin
          cam_d = cam_q;
        end
      end else if (tick_s) begin
        tckc_d = tckc_q + PERIOD_W'(1);
        vr_d   = (tckc_q == (period_s >> 1)) ? 1'b1 : vr_q;
      end else begin
        tckc_d = tckc_q;
      end
      gap_d = (tooth_d == LAST_TOOTH);
      case (state_q)
        GEN_STOP:  state_d = (tooth_d == LAST_TOOTH) ? GEN_GAP : GEN_TOOTH;
        GEN_TOOTH: state_d = (boundary_s && (next_tooth_s == LAST_TOOTH)) ? GEN_GAP : GEN_TOOTH;
        GEN_GAP:   state_d = boundary_s ? GEN_TOOTH : GEN_GAP;
        default:   state_d = GEN_STOP;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GEN_STOP;
      tooth_q <= '0;
      tckc_q  <= '0;
      tt_q    <= '0;
      vr_q    <= 1'b0;
      cam_q   <= ~CAM_ACTIVE;
      gap_q   <= 1'b0;
      phase_q <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tooth_q <= tooth_d;
      tckc_q  <= tckc_d;
      tt_q    <= tt_d;
      vr_q    <= vr_d;
      cam_q   <= cam_d;
      gap_q   <= gap_d;
      phase_q <= phase_d;
      rev_q   <= rev_d;
    end
  end

  assign vr_o         = vr_q;
  assign cam_o        = cam_q;
  assign tooth_o      = tooth_q;
  assign gap_o        = gap_q;
  assign phase_o      = phase_q;
  assign rev_strobe_o = rev_q;

endmodule

// File: tb/tb_crank_cam_gen.sv
// Bench for crank_cam_gen: a tooth-level timing model (durations and vr rise
// offsets from wheel arithmetic) is compared against the DUT every clock.
module tb_crank_cam_gen;

  localparam int REAL = 58;
  localparam int MISS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0, ramp_en = 1'b0, ramp_dir = 1'b0;
  logic [7:0] presc_top = 8'd0, tooth_ticks = 8'd0, ramp_limit = 8'd0;
  logic [5:0] start_tooth = 6'd0, cam_on = 6'd0, cam_off = 6'd0;
  logic vr, cam, gap, phase, rev_strobe;
  logic [5:0] tooth;
  logic [7:0] presc_cur;
  logic [10:0] obs;

  int n_vec = 0;
  int n_err = 0;

  int m_tooth, m_el, m_presc, m_tt;
  logic m_phase, m_cam, m_rev;

  always #5 clk = ~clk;

  crank_cam_gen #(
    .TEETH_TOTAL(60), .TEETH_MISSING(2), .PRESC_W(8), .TICK_W(8), .CAM_ACTIVE(1'b0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .presc_top_i(presc_top),
    .tooth_ticks_i(tooth_ticks), .ramp_en_i(ramp_en), .ramp_dir_i(ramp_dir),
    .ramp_limit_i(ramp_limit), .start_tooth_i(start_tooth), .cam_on_tooth_i(cam_on),
    .cam_off_tooth_i(cam_off), .vr_o(vr), .cam_o(cam), .tooth_o(tooth), .gap_o(gap),
    .phase_o(phase), .rev_strobe_o(rev_strobe), .presc_cur_o(presc_cur)
  );

  assign obs = {vr, cam, gap, phase, rev_strobe, tooth};

  function automatic int per_of(input int t, input int tt);
    return (t == REAL - 1) ? (MISS + 1) * (tt + 1) - 1 : tt;
  endfunction

  function automatic logic [10:0] exp_vec();
    int per, rise;
    per  = per_of(m_tooth, m_tt);
    rise = ((per >> 1) + 1) * (m_presc + 1);
    return {(m_el >= rise) ? 1'b1 : 1'b0, m_cam, (m_tooth == REAL - 1) ? 1'b1 : 1'b0,
            m_phase, m_rev, 6'(m_tooth)};
  endfunction

  task automatic model_reset();
    m_tooth = 0; m_phase = 1'b0; m_cam = 1'b1; m_presc = int'(presc_top);
    m_tt = int'(tooth_ticks); m_el = 0; m_rev = 1'b0;
  endtask

  // Advance the model by one clock using the inputs seen at that edge.
  task automatic model_step();
    int per;
    if (!ena) begin
      model_reset();
      m_tooth = (int'(start_tooth) < REAL) ? int'(start_tooth) : 0;
    end else begin
      m_rev = 1'b0;
      m_el++;
      per = per_of(m_tooth, m_tt);
      if (m_el == (per + 1) * (m_presc + 1)) begin
        if (ramp_en && ramp_dir && m_presc < int'(ramp_limit)) m_presc++;
        else if (ramp_en && !ramp_dir && m_presc > int'(ramp_limit)) m_presc--;
        m_tooth = (m_tooth + 1) % REAL;
        if (m_tooth == 0) begin m_phase = ~m_phase; m_rev = 1'b1; end
        if (m_tooth == int'(cam_off)) m_cam = 1'b1;
        else if (m_tooth == int'(cam_on) && m_phase) m_cam = 1'b0;
        m_tt = int'(tooth_ticks);
        m_el = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic configure(input int p, input int tt, input int st, input int con,
                           input int coff, input int ren, input int rdir, input int rlim);
    ena = 1'b0;
    presc_top = 8'(p); tooth_ticks = 8'(tt); start_tooth = 6'(st);
    cam_on = 6'(con); cam_off = 6'(coff);
    ramp_en = 1'(ren); ramp_dir = 1'(rdir); ramp_limit = 8'(rlim);
    cycle(); cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== 11'b010_0000_0000) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=%b", obs, 11'b010_0000_0000);
    end
    n_vec++;
    if (presc_cur !== 8'd0) begin n_err++; $display("FAIL reset_presc got=%0d exp=0", presc_cur); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int last_rev, n_rev, chg_at;
    logic prev_vr;
    logic [5:0] prev_tooth;
    configure(0, 3, 0, 4, 54, 0, 0, 0);
    ena = 1'b1; last_rev = 0; n_rev = 0; chg_at = 0; prev_vr = vr; prev_tooth = tooth;
    for (int i = 1; i <= 520; i++) begin
      cycle();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL basic cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      if (tooth !== prev_tooth) chg_at = i;
      if (vr && !prev_vr) begin
        n_vec++;
        if (i - chg_at != ((tooth == 6'd57) ? 6 : 2)) begin
          n_err++; $display("FAIL vr_rise tooth=%0d got=%0d exp=%0d", tooth, i - chg_at, (tooth == 6'd57) ? 6 : 2);
        end
      end
      if (rev_strobe) begin
        n_rev++; n_vec++;
        if (i - last_rev != 240) begin
          n_err++; $display("FAIL rev_period got=%0d exp=240", i - last_rev);
        end
        last_rev = i;
      end
      prev_vr = vr; prev_tooth = tooth;
    end
    n_vec++;
    if (n_rev != 2) begin n_err++; $display("FAIL rev_count got=%0d exp=2", n_rev); end
  endtask

  task automatic test_ramp(input int dir, input int lim);
    int nb, exp_p;
    logic [5:0] prev_tooth;
    configure(3, 3, 0, 4, 54, 1, dir, lim);
    ena = 1'b1; nb = 0; prev_tooth = tooth;
    for (int i = 1; i <= 200; i++) begin
      cycle();
      if (tooth !== prev_tooth) nb++;
      prev_tooth = tooth;
      exp_p = (nb == 0) ? 3 : (nb == 1) ? (dir ? 4 : 2) : lim;
      n_vec++;
      if (obs !== exp_vec() || presc_cur !== 8'(exp_p) || exp_p != m_presc) begin
        n_err++;
        $display("FAIL ramp dir=%0d cyc=%0d got=%b/%0d exp=%b/%0d", dir, i, obs, presc_cur, exp_vec(), exp_p);
      end
    end
  endtask

  task automatic test_reinit();
    int found;
    configure(0, 3, 45, 4, 54, 0, 0, 0);
    ena = 1'b1; found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cycle();
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL reinit_run cyc=%0d got=%b exp=%b", i, obs, exp_vec()); end
      if (m_tooth == 50 && m_el == 3) found = 1;
    end
    n_vec++;
    if (found == 0) begin n_err++; $display("FAIL reinit_reach got=0 exp=1"); end
    ena = 1'b0;
    cycle();
    n_vec++;
    if ({vr, tooth, phase, cam} !== {1'b0, 6'd45, 1'b0, 1'b1} || obs !== exp_vec()) begin
      n_err++; $display("FAIL reinit_drop got=%b exp=%b", {vr, tooth, phase, cam}, {1'b0, 6'd45, 1'b0, 1'b1});
    end
    start_tooth = 6'd62;
    cycle();
    n_vec++;
    if (tooth !== 6'd0 || gap !== 1'b0) begin n_err++; $display("FAIL start_oor got=%0d/%b exp=0/0", tooth, gap); end
    start_tooth = 6'd57;
    cycle();
    n_vec++;
    if (tooth !== 6'd57 || gap !== 1'b1) begin n_err++; $display("FAIL start_gap got=%0d/%b exp=57/1", tooth, gap); end
    ena = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL gap_start cyc=%0d got=%b exp=%b", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_rst_gap();
    int found, first_chg;
    configure(0, 0, 0, 4, 54, 0, 0, 0);
    ena = 1'b1; found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cycle();
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL rstgap_run cyc=%0d got=%b exp=%b", i, obs, exp_vec()); end
      if (m_tooth == 57) found = 1;
    end
    n_vec++;
    if (gap !== 1'b1) begin n_err++; $display("FAIL rstgap_in_gap got=%b exp=1", gap); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== 11'b010_0000_0000 || presc_cur !== 8'd0) begin
      n_err++; $display("FAIL async_reset got=%b/%0d exp=%b/0", obs, presc_cur, 11'b010_0000_0000);
    end
    presc_top = 8'd2; tooth_ticks = 8'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    first_chg = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      n_vec++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, obs, exp_vec()); end
      if (first_chg == 0 && tooth !== 6'd0) first_chg = i;
    end
    n_vec++;
    if (first_chg != 3) begin n_err++; $display("FAIL first_tick got=%0d exp=3", first_chg); end
  endtask

  task automatic test_random();
    int run;
    for (int r = 0; r < 6; r++) begin
      configure($urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 63),
                $urandom_range(0, 57), $urandom_range(0, 57), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 3));
      ena = 1'b1; run = 0;
      for (int i = 0; i < 900; i++) begin
        cycle();
        n_vec++;
        if (obs !== exp_vec()) begin
          n_err++; $display("FAIL random run=%0d cyc=%0d got=%b exp=%b", r, i, obs, exp_vec());
        end
        run = ena ? run + 1 : 0;
        if (ena && run >= 3 && $urandom_range(0, 39) == 0) tooth_ticks = 8'($urandom_range(0, 4));
        if ($urandom_range(0, 24) == 0) begin
          cam_on = 6'($urandom_range(0, 57)); cam_off = 6'($urandom_range(0, 57));
        end
        if ($urandom_range(0, 29) == 0) ramp_dir = 1'($urandom_range(0, 1));
        if (ena && $urandom_range(0, 299) == 0) ena = 1'b0;
        else if (!ena && $urandom_range(0, 2) == 0) ena = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ramp(1, 5);
    test_ramp(0, 1);
    test_reinit();
    test_rst_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
